seq_alu: RTL and testbench
==========================

Name: seq_alu

Overview:
- Parametrised, registered successor to the combinational datapath ALU.
- Adds a valid/ready issue handshake, multi-cycle iterative shifts, and unsigned multiply and divide with a hi/lo result pair.
- Sits in the execute stage; the pipeline stalls on in_ready=0 and captures results on out_valid.

Parameters:
WIDTH, 32, datapath width; power of 2, >= 8.
SHIFT_STEP, 1, bits shifted per cycle; power of 2, 1..WIDTH.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  reset, synchronous, active-high.
in_valid  input  1  operation request.
in_ready  output  1  block can accept an operation (FSM in IDLE and rst=0).
opcode  input  4  operation select.
a  input  WIDTH  operand A.
b  input  WIDTH  operand B; for shifts, amount = b[log2(WIDTH)-1:0], upper bits ignored.
out_valid  output  1  one-cycle pulse: result fields are valid.
result  output  WIDTH  primary result (MULU low word, DIVU quotient).
result_hi  output  WIDTH  MULU high word, DIVU remainder; 0 for all other ops.
zero  output  1  result == 0.
overflow  output  1  signed overflow; ADD/SUB only, 0 for all other ops.
div_by_zero  output  1  DIVU with b == 0.

Behaviour:
- Opcodes:
  - 0000 ADD
  - 0001 SUB (a-b)
  - 0010 AND
  - 0011 OR
  - 0100 XOR
  - 0101 LUI: result = {a[WIDTH/2-1:0], WIDTH/2 zeros}
  - 0110 SLL
  - 0111 SRL
  - 1000 SRA (sign-fill)
  - 1001 SLT: signed, result = 1 or 0
  - 1010 MULU: unsigned, 2*WIDTH product
  - 1011 DIVU: unsigned, restoring
  - 1100-1111 illegal: result=0, result_hi=0, zero=1, other flags 0, latency 1
- Handshake:
  - Acceptance = in_valid && in_ready at a rising edge.
  - Operands and opcode are latched at acceptance; input changes afterwards have no effect.
  - in_valid while busy is ignored and not queued.
- FSM states:
  - IDLE: in_ready=1. On acceptance, go to SHIFT, MUL or DIV for multi-cycle ops. Single-cycle ops stay in IDLE.
  - SHIFT: shifts SHIFT_STEP bits per cycle; the final step shifts only the remaining bits.
  - MUL: shift-add, one bit per cycle.
  - DIV: restoring, one quotient bit per cycle.
  - Completion writes the output registers, pulses out_valid and returns to IDLE in the same edge.
- Latency is counted from the acceptance edge to the edge at which out_valid goes high:
  - Single-cycle ops: 1. Back-to-back issue gives 1 op/cycle; in_ready=1 during the out_valid cycle.
  - Shifts: 1 + ceil(amt/SHIFT_STEP); amt=0 gives latency 1 and result=a.
  - MULU: 1 + WIDTH.
  - DIVU: 1 + WIDTH. If b=0: latency 1, result=all ones, result_hi=a, div_by_zero=1.
- Flags:
  - zero is evaluated on result only.
  - overflow for ADD: operand signs equal and result sign differs.
  - overflow for SUB: operand signs differ and result sign differs from a.
  - All flags are registered together with result.
- Output hold: result, result_hi and flags hold their values until the next out_valid; out_valid=0 otherwise.
- Reset:
  - Values: result=0, result_hi=0, zero=0, overflow=0, div_by_zero=0, out_valid=0, in_ready=0 while rst=1, FSM=IDLE, iteration counter=0.
  - rst during any state aborts the operation; no out_valid for it.
  - in_ready=1 in the first cycle with rst=0.
- Arithmetic is modulo 2^WIDTH except the MULU hi/lo pair.
- Iteration counter width is log2(WIDTH)+1.

Decomposition:
- Package seq_alu_pkg holds:
  - the opcode localparams (OP_ADD..OP_DIVU)
  - the FSM state encoding (ST_IDLE, ST_SHIFT, ST_MUL, ST_DIV)
  - a clog2 helper function
- Sub-module seq_muldiv (iterative MULU/DIVU core) has start, busy, done, a, b, lo, hi and dbz ports, and is parametrised by WIDTH.
- Shifts and single-cycle ops stay in seq_alu.

Test Plan:
- ADD a=0x7FFFFFFF b=1 -> result=0x80000000, overflow=1, zero=0, out_valid 1 cycle after accept; SUB a=5 b=5 issued the next cycle -> result=0, zero=1, overflow=0.
- SRA a=0x80000000 b=0x24 (amt=4), SHIFT_STEP=1 -> result=0xF8000000, out_valid 5 cycles after accept; in_ready=0 during cycles 1-4; in_valid pulse at cycle 2 ignored (no extra out_valid).
- MULU a=0xFFFFFFFF b=2 -> result=0xFFFFFFFE, result_hi=1, latency 33; SLT a=0xFFFFFFFF b=1 -> result=1.
- DIVU a=100 b=7 -> result=14, result_hi=2, latency 33; DIVU a=100 b=0 -> result=0xFFFFFFFF, result_hi=100, div_by_zero=1, latency 1.
- rst asserted 10 cycles into MULU for 1 cycle -> no out_valid for it, all outputs 0, in_ready=1 the cycle after rst falls; a following ADD 3+4 -> 7 at latency 1.
- Illegal opcode 4'b1111 -> result=0, zero=1, latency 1; SHIFT_STEP=4 SLL a=1 b=31 -> result=0x80000000, latency 9.

Source files
------------

// File: rtl/seq_alu_pkg.sv
// Shared opcodes, FSM encoding and elaboration helpers for the sequential ALU.
package seq_alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_XOR  = 4'h4;
    localparam logic [3:0] OP_LUI  = 4'h5;
    localparam logic [3:0] OP_SLL  = 4'h6;
    localparam logic [3:0] OP_SRL  = 4'h7;
    localparam logic [3:0] OP_SRA  = 4'h8;
    localparam logic [3:0] OP_SLT  = 4'h9;
    localparam logic [3:0] OP_MULU = 4'hA;
    localparam logic [3:0] OP_DIVU = 4'hB;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_MUL,
        ST_DIV
    } state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/seq_alu_if.sv
// Issue/result bundle between the execute stage and seq_alu.
interface seq_alu_if #(parameter int WIDTH = 32);

    logic             in_valid;
    logic             in_ready;
    logic [3:0]       opcode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] result_hi;
    logic             zero;
    logic             overflow;
    logic             div_by_zero;

    modport master (
        output in_valid, opcode, a, b,
        input  in_ready, out_valid, result, result_hi, zero, overflow, div_by_zero
    );

    modport slave (
        input  in_valid, opcode, a, b,
        output in_ready, out_valid, result, result_hi, zero, overflow, div_by_zero
    );

endinterface

// File: rtl/seq_muldiv.sv
// Iterative unsigned multiply (shift-add) and restoring divide, one bit per cycle.
// lo/hi/done present the final step combinationally so the caller registers them on that edge.
module seq_muldiv
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi,
    output logic             dbz
);

    localparam int CW = clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic             div_q;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   rsh;
    logic [WIDTH:0]   diff;

    assign dbz  = (b == '0);
    assign done = busy && (cnt == LAST);

    // acc_lo holds the multiplier (MUL) or the dividend shifting into the quotient (DIV)
    always_comb begin
        sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mcand} : '0);
        rsh  = {acc_hi, acc_lo[WIDTH-1]};
        diff = rsh - {1'b0, mcand};
        if (!div_q) begin
            hi = sum[WIDTH:1];
            lo = {sum[0], acc_lo[WIDTH-1:1]};
        end else if (!diff[WIDTH]) begin
            hi = diff[WIDTH-1:0];
            lo = {acc_lo[WIDTH-2:0], 1'b1};
        end else begin
            hi = rsh[WIDTH-1:0];
            lo = {acc_lo[WIDTH-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy   <= 1'b0;
            div_q  <= 1'b0;
            cnt    <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            mcand  <= '0;
        end else if (start) begin
            busy   <= 1'b1;
            div_q  <= is_div;
            cnt    <= '0;
            acc_hi <= '0;
            acc_lo <= a;
            mcand  <= b;
        end else if (busy) begin
            acc_hi <= hi;
            acc_lo <= lo;
            cnt    <= cnt + 1'b1;
            if (cnt == LAST) busy <= 1'b0;
        end
    end

endmodule

// File: rtl/seq_alu.sv
// Registered execute-stage ALU: single-cycle ops complete at acceptance,
// shifts iterate SHIFT_STEP bits per cycle, MULU/DIVU run in seq_muldiv.
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int SHIFT_STEP = 1
) (
    input  logic      clk,
    input  logic      rst,
    seq_alu_if.slave  bus
);

    localparam int SW = clog2(WIDTH);
    localparam int CW = SW + 1;
    localparam logic [CW-1:0] STEP = CW'(SHIFT_STEP);

    state_t           state;
    logic [3:0]       op_q;
    logic [WIDTH-1:0] sh;
    logic [CW-1:0]    cnt;

    logic             in_ready, accept, is_shift;
    logic [CW-1:0]    amt, step;
    logic [WIDTH-1:0] sum, dif, sc_res, sh_nxt;
    logic             sc_ovf;
    logic             fin, fin_ovf, fin_dbz;
    logic [WIDTH-1:0] fin_res, fin_hi;
    logic             md_start, md_busy, md_done, md_dbz;
    logic [WIDTH-1:0] md_lo, md_hi;

    assign in_ready     = (state == ST_IDLE) && !md_busy && !rst;
    assign bus.in_ready = in_ready;
    assign accept       = bus.in_valid && in_ready;
    assign amt          = {1'b0, bus.b[SW-1:0]};
    assign is_shift     = (bus.opcode == OP_SLL) || (bus.opcode == OP_SRL) || (bus.opcode == OP_SRA);
    assign md_start     = accept && ((bus.opcode == OP_MULU) || (bus.opcode == OP_DIVU && !md_dbz));

    always_comb begin
        sum    = bus.a + bus.b;
        dif    = bus.a - bus.b;
        sc_res = '0;
        sc_ovf = 1'b0;
        case (bus.opcode)
            OP_ADD: begin
                sc_res = sum;
                sc_ovf = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_SUB: begin
                sc_res = dif;
                sc_ovf = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (dif[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_AND: sc_res = bus.a & bus.b;
            OP_OR:  sc_res = bus.a | bus.b;
            OP_XOR: sc_res = bus.a ^ bus.b;
            OP_LUI: sc_res = {bus.a[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
            OP_SLT: sc_res = {{(WIDTH-1){1'b0}}, $signed(bus.a) < $signed(bus.b)};
            default: ;
        endcase
    end

    // Last step shifts only what is left of the amount
    always_comb begin
        step = (cnt < STEP) ? cnt : STEP;
        case (op_q)
            OP_SLL:  sh_nxt = sh << step;
            OP_SRL:  sh_nxt = sh >> step;
            default: sh_nxt = $signed(sh) >>> step;
        endcase
    end

    always_comb begin
        fin     = 1'b0;
        fin_res = sc_res;
        fin_hi  = '0;
        fin_ovf = 1'b0;
        fin_dbz = 1'b0;
        case (state)
            ST_IDLE: if (accept) begin
                if (is_shift) begin
                    fin     = (amt == '0);
                    fin_res = bus.a;
                end else if (bus.opcode == OP_DIVU) begin
                    fin     = md_dbz;
                    fin_res = '1;
                    fin_hi  = bus.a;
                    fin_dbz = 1'b1;
                end else if (bus.opcode != OP_MULU) begin
                    fin     = 1'b1;
                    fin_ovf = sc_ovf;
                end
            end
            ST_SHIFT: begin
                fin     = (cnt == step);
                fin_res = sh_nxt;
            end
            default: begin
                fin     = md_done;
                fin_res = md_lo;
                fin_hi  = md_hi;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= ST_IDLE;
            op_q            <= OP_ADD;
            sh              <= '0;
            cnt             <= '0;
            bus.out_valid   <= 1'b0;
            bus.result      <= '0;
            bus.result_hi   <= '0;
            bus.zero        <= 1'b0;
            bus.overflow    <= 1'b0;
            bus.div_by_zero <= 1'b0;
        end else begin
            bus.out_valid <= fin;
            if (fin) begin
                bus.result      <= fin_res;
                bus.result_hi   <= fin_hi;
                bus.zero        <= (fin_res == '0);
                bus.overflow    <= fin_ovf;
                bus.div_by_zero <= fin_dbz;
            end
            case (state)
                ST_IDLE: if (accept) begin
                    op_q <= bus.opcode;
                    sh   <= bus.a;
                    cnt  <= amt;
                    if (is_shift && amt != '0)                  state <= ST_SHIFT;
                    else if (bus.opcode == OP_MULU)             state <= ST_MUL;
                    else if (bus.opcode == OP_DIVU && !md_dbz)  state <= ST_DIV;
                end
                ST_SHIFT: begin
                    sh  <= sh_nxt;
                    cnt <= cnt - step;
                    if (cnt == step) state <= ST_IDLE;
                end
                default: if (md_done) state <= ST_IDLE;
            endcase
        end
    end

    seq_muldiv #(.WIDTH(WIDTH)) u_muldiv (
        .clk    (clk),
        .rst    (rst),
        .start  (md_start),
        .is_div (bus.opcode == OP_DIVU),
        .a      (bus.a),
        .b      (bus.b),
        .busy   (md_busy),
        .done   (md_done),
        .lo     (md_lo),
        .hi     (md_hi),
        .dbz    (md_dbz)
    );

endmodule

// File: tb/tb_seq_alu.sv
// Directed-vector bench for seq_alu: SHIFT_STEP=1 and SHIFT_STEP=4 instances.
module tb_seq_alu;
    import seq_alu_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    seq_alu_if #(.WIDTH(32)) bus0 ();
    seq_alu_if #(.WIDTH(32)) bus1 ();

    seq_alu #(.WIDTH(32), .SHIFT_STEP(1)) u0 (.clk(clk), .rst(rst), .bus(bus0));
    seq_alu #(.WIDTH(32), .SHIFT_STEP(4)) u1 (.clk(clk), .rst(rst), .bus(bus1));

    int passes = 0;
    int fails  = 0;
    int total  = 0;
    int lat;
    int cnt_bad;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit sel, input logic v, input logic [3:0] op,
                         input logic [31:0] a, input logic [31:0] b);
        if (sel) begin
            bus1.in_valid = v; bus1.opcode = op; bus1.a = a; bus1.b = b;
        end else begin
            bus0.in_valid = v; bus0.opcode = op; bus0.a = a; bus0.b = b;
        end
    endtask

    // Leaves the bench 1 time unit after the acceptance edge
    task automatic issue(input bit sel, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        drive(sel, 1'b1, op, a, b);
        @(posedge clk);
        #1;
        drive(sel, 1'b0, op, a, b);
    endtask

    function automatic logic ov(input bit sel);
        return sel ? bus1.out_valid : bus0.out_valid;
    endfunction

    task automatic wait_out(input bit sel, output int l);
        l = 1;
        while (!ov(sel) && l < 100) begin
            @(posedge clk);
            #1;
            l++;
        end
    endtask

    initial begin
        drive(0, 1'b0, OP_ADD, 32'h0, 32'h0);
        drive(1, 1'b0, OP_ADD, 32'h0, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_result", {bus0.result_hi, bus0.result}, 64'h0);
        chk("rst_flags", {bus0.zero, bus0.overflow, bus0.div_by_zero, bus0.out_valid, bus0.in_ready}, 5'b0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rdy_first_cycle", bus0.in_ready, 1'b1);

        // ADD overflow then SUB issued back-to-back
        @(negedge clk);
        drive(0, 1'b1, OP_ADD, 32'h7FFF_FFFF, 32'h1);
        @(posedge clk);
        #1;
        chk("add_valid", bus0.out_valid, 1'b1);
        chk("add_result", bus0.result, 32'h8000_0000);
        chk("add_zero_ovf", {bus0.zero, bus0.overflow}, 2'b01);
        chk("add_ready", bus0.in_ready, 1'b1);
        drive(0, 1'b1, OP_SUB, 32'd5, 32'd5);
        @(posedge clk);
        #1;
        chk("sub_valid", bus0.out_valid, 1'b1);
        chk("sub_result", bus0.result, 32'h0);
        chk("sub_zero_ovf", {bus0.zero, bus0.overflow}, 2'b10);
        drive(0, 1'b0, OP_ADD, 32'h0, 32'h0);
        @(posedge clk);
        #1;
        chk("sub_pulse", bus0.out_valid, 1'b0);
        chk("sub_hold", {bus0.zero, bus0.result}, {1'b1, 32'h0});

        // SRA by 4 with a stray request while busy
        issue(0, OP_SRA, 32'h8000_0000, 32'h24);
        cnt_bad = 0;
        for (int c = 1; c <= 4; c++) begin
            if (bus0.out_valid || bus0.in_ready) cnt_bad++;
            if (c == 2) drive(0, 1'b1, OP_ADD, 32'h1, 32'h1);
            if (c == 3) drive(0, 1'b0, OP_ADD, 32'h1, 32'h1);
            @(posedge clk);
            #1;
        end
        chk("sra_busy", cnt_bad, 0);
        chk("sra_valid_lat5", bus0.out_valid, 1'b1);
        chk("sra_result", bus0.result, 32'hF800_0000);
        @(posedge clk);
        #1;
        chk("sra_no_extra", bus0.out_valid, 1'b0);

        issue(0, OP_MULU, 32'hFFFF_FFFF, 32'h2);
        wait_out(0, lat);
        chk("mul_lat", lat, 33);
        chk("mul_hi_lo", {bus0.result_hi, bus0.result}, 64'h1_FFFF_FFFE);

        issue(0, OP_SLT, 32'hFFFF_FFFF, 32'h1);
        wait_out(0, lat);
        chk("slt_lat", lat, 1);
        chk("slt_hi_lo", {bus0.result_hi, bus0.result}, 64'h1);

        issue(0, OP_DIVU, 32'd100, 32'd7);
        wait_out(0, lat);
        chk("div_lat", lat, 33);
        chk("div_hi_lo", {bus0.result_hi, bus0.result}, {32'd2, 32'd14});
        chk("div_dbz", bus0.div_by_zero, 1'b0);

        issue(0, OP_DIVU, 32'd100, 32'd0);
        wait_out(0, lat);
        chk("div0_lat", lat, 1);
        chk("div0_hi_lo", {bus0.result_hi, bus0.result}, {32'd100, 32'hFFFF_FFFF});
        chk("div0_dbz_zero", {bus0.div_by_zero, bus0.zero}, 2'b10);

        issue(0, OP_LUI, 32'h1234_ABCD, 32'h0);
        wait_out(0, lat);
        chk("lui_result", {bus0.result_hi, bus0.result}, 64'hABCD_0000);

        issue(0, OP_SLL, 32'h0000_1234, 32'h20);
        wait_out(0, lat);
        chk("sll0_lat", lat, 1);
        chk("sll0_result", bus0.result, 32'h0000_1234);

        // Reset 10 cycles into a multiply aborts it
        issue(0, OP_MULU, 32'd3, 32'd5);
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_result", {bus0.result_hi, bus0.result}, 64'h0);
        chk("abort_flags", {bus0.zero, bus0.overflow, bus0.div_by_zero, bus0.out_valid, bus0.in_ready}, 5'b0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("abort_ready", bus0.in_ready, 1'b1);
        cnt_bad = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (bus0.out_valid) cnt_bad++;
        end
        chk("abort_no_valid", cnt_bad, 0);

        issue(0, OP_ADD, 32'd3, 32'd4);
        wait_out(0, lat);
        chk("add7_lat", lat, 1);
        chk("add7_result", bus0.result, 32'd7);

        issue(0, 4'hF, 32'd5, 32'd3);
        wait_out(0, lat);
        chk("ill_lat", lat, 1);
        chk("ill_hi_lo", {bus0.result_hi, bus0.result}, 64'h0);
        chk("ill_flags", {bus0.zero, bus0.overflow, bus0.div_by_zero}, 3'b100);

        issue(1, OP_SLL, 32'h1, 32'd31);
        wait_out(1, lat);
        chk("sll4_lat", lat, 9);
        chk("sll4_result", bus1.result, 32'h8000_0000);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
